// File: rtl/latency_probe_gen.sv
// Timestamped AXI-stream probe source: every beat carries the timer value at launch,
// tuser carries a has_time header plus the packet launch time.
module latency_probe_gen #(
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_SPP_SHIFT = 11,
    parameter int GAP_WIDTH     = 16
) (
    input  logic                  ce_clk,
    input  logic                  reset,
    input  logic                  clear_tx_seqnum,
    input  logic                  enable,
    input  logic [3:0]            spp_shift,
    input  logic [GAP_WIDTH-1:0]  gap_cycles,
    input  logic [15:0]           num_packets,
    input  logic [15:0]           src_sid,
    input  logic [15:0]           next_dst_sid,
    input  logic [63:0]           timer,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tlast,
    output logic                  o_tvalid,
    input  logic                  o_tready,
    output logic [127:0]          o_tuser,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           pkt_sent_count
);

    localparam int SPP_W = MAX_SPP_SHIFT + 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t                r_state;
    logic [SPP_W-1:0]      r_spp_m1;
    logic [GAP_WIDTH-1:0]  r_gap;
    logic [15:0]           r_num;
    logic [SPP_W-1:0]      r_beat_cnt;
    logic [GAP_WIDTH-1:0]  r_gap_cnt;
    logic [11:0]           r_seq;
    logic [15:0]           r_pkt_cnt;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tlast;
    logic                  r_tvalid;
    logic [63:0]           r_pkt_time;
    logic [63:0]           r_hdr;
    logic                  r_busy;
    logic                  r_done;

    logic [3:0]       w_shift;
    logic [SPP_W-1:0] w_spp_m1;
    logic             w_accept;
    logic             w_last_accept;
    logic [15:0]      w_cnt_inc;
    logic [15:0]      w_cnt_now;
    logic [11:0]      w_seq_next;
    logic             w_run_done;
    logic             w_eob_next;
    logic             w_eob_first;
    logic [63:0]      w_hdr_first;
    logic [63:0]      w_hdr_next;

    assign w_shift  = ({28'd0, spp_shift} > MAX_SPP_SHIFT) ? 4'(MAX_SPP_SHIFT) : spp_shift;
    assign w_spp_m1 = (SPP_W'(1) << w_shift) - SPP_W'(1);

    assign w_accept      = r_tvalid && o_tready;
    assign w_last_accept = w_accept && r_tlast;
    assign w_cnt_inc     = (r_pkt_cnt == 16'hFFFF) ? r_pkt_cnt : r_pkt_cnt + 16'd1;
    assign w_cnt_now     = w_last_accept ? w_cnt_inc : r_pkt_cnt;
    assign w_run_done    = (r_num != 16'd0) && (w_cnt_inc == r_num);

    // The header of a packet started on this edge must already see the post-edge seqnum.
    assign w_seq_next = clear_tx_seqnum ? 12'd0 : (w_last_accept ? r_seq + 12'd1 : r_seq);

    assign w_eob_first = (num_packets == 16'd1);
    assign w_eob_next  = (r_num != 16'd0) && (({1'b0, w_cnt_now} + 17'd1) == {1'b0, r_num});

    assign w_hdr_first = {2'b00, 1'b1, w_eob_first, w_seq_next, 16'd0, src_sid, next_dst_sid};
    assign w_hdr_next  = {2'b00, 1'b1, w_eob_next,  w_seq_next, 16'd0, src_sid, next_dst_sid};

    always_ff @(posedge ce_clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_spp_m1   <= '0;
            r_gap      <= '0;
            r_num      <= '0;
            r_beat_cnt <= '0;
            r_gap_cnt  <= '0;
            r_seq      <= '0;
            r_pkt_cnt  <= '0;
            r_tdata    <= '0;
            r_tlast    <= 1'b0;
            r_tvalid   <= 1'b0;
            r_pkt_time <= '0;
            r_hdr      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_seq <= w_seq_next;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_spp_m1   <= w_spp_m1;
                        r_gap      <= gap_cycles;
                        r_num      <= num_packets;
                        r_pkt_cnt  <= '0;
                        r_beat_cnt <= '0;
                        r_tdata    <= timer[DATA_WIDTH-1:0];
                        r_pkt_time <= timer;
                        r_hdr      <= w_hdr_first;
                        r_tlast    <= (w_spp_m1 == '0);
                        r_tvalid   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (w_accept && !r_tlast) begin
                        r_beat_cnt <= r_beat_cnt + SPP_W'(1);
                        r_tdata    <= timer[DATA_WIDTH-1:0];
                        r_tlast    <= ((r_beat_cnt + SPP_W'(1)) == r_spp_m1);
                    end else if (w_accept) begin
                        r_pkt_cnt  <= w_cnt_inc;
                        r_beat_cnt <= '0;
                        if (w_run_done) begin
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (!enable) begin
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_busy   <= 1'b0;
                            r_state  <= S_IDLE;
                        end else if (r_gap == '0) begin
                            r_tdata    <= timer[DATA_WIDTH-1:0];
                            r_pkt_time <= timer;
                            r_hdr      <= w_hdr_next;
                            r_tlast    <= (r_spp_m1 == '0);
                        end else begin
                            r_tvalid  <= 1'b0;
                            r_tlast   <= 1'b0;
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
                        end
                    end
                end

                S_GAP: begin
                    if (!enable) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_gap_cnt == (r_gap - GAP_WIDTH'(1))) begin
                        r_tdata    <= timer[DATA_WIDTH-1:0];
                        r_pkt_time <= timer;
                        r_hdr      <= w_hdr_next;
                        r_tlast    <= (r_spp_m1 == '0);
                        r_tvalid   <= 1'b1;
                        r_state    <= S_SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_WIDTH'(1);
                    end
                end

                S_DONE: begin
                    if (!enable) begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_tdata        = r_tdata;
    assign o_tlast        = r_tlast;
    assign o_tvalid       = r_tvalid;
    assign o_tuser        = {r_hdr, r_pkt_time};
    assign busy           = r_busy;
    assign done           = r_done;
    assign pkt_sent_count = r_pkt_cnt;

endmodule

// File: doc/latency_probe_gen.md
Name: latency_probe_gen

Overview:
- Upstream stimulus stage for the latency-measurement loop.
- Emits timestamped AXI-stream probe packets into the axi_wrapper s_axis data path. Every sample carries the local timer value at launch; the packet tuser carries a has_time header plus the packet launch time.
- After the packets traverse the RFNoC graph, the downstream latency-report block subtracts these stamps from its own timer to compute per-sample and per-packet latency.
- Burst length, packets-per-second pacing (inter-packet gap) and run length are all configurable.

Parameters:
- DATA_WIDTH, 32, sample width; the stamp is timer[DATA_WIDTH-1:0].
- MAX_SPP_SHIFT, 11, upper clamp on spp_shift (max 2048 samples per packet).
- GAP_WIDTH, 16, width of the inter-packet gap counter.

Ports:
- ce_clk  in  1  clock
- reset  in  1  synchronous, active-high; clock ce_clk
- clear_tx_seqnum  in  1  zeroes the 12-bit sequence number
- enable  in  1  level; run while high
- spp_shift  in  4  samples per packet = 1<<min(spp_shift, MAX_SPP_SHIFT)
- gap_cycles  in  GAP_WIDTH  idle cycles between packets
- num_packets  in  16  packets per run; 0 = unlimited
- src_sid  in  16  header source SID
- next_dst_sid  in  16  header destination SID
- timer  in  64  shared free-running time
- o_tdata  out  DATA_WIDTH  sample stamp
- o_tlast  out  1  last beat of packet
- o_tvalid  out  1  beat valid
- o_tready  in  1  downstream ready
- o_tuser  out  128  {header[63:0], pkt_time[63:0]}
- busy  out  1  state != IDLE
- done  out  1  finite run complete
- pkt_sent_count  out  16  packets completed in the current run

Behaviour:
- Reset: state IDLE; o_tvalid, o_tlast, o_tdata, o_tuser, busy, done and pkt_sent_count all 0; seqnum 0; beat and gap counters 0.
- States: IDLE, SEND, GAP, DONE.
- IDLE -> SEND: when enable=1.
  - Latch spp (clamped), gap_cycles and num_packets; these are held for the whole run.
  - Clear pkt_sent_count.
  - Load o_tdata <= timer[DATA_WIDTH-1:0] and pkt_time <= timer.
  - o_tvalid rises on the next cycle, so stamp latency is 1 cycle.
- SEND:
  - o_tvalid=1.
  - o_tdata, o_tlast and o_tuser are registered and held stable while o_tvalid && !o_tready.
  - On each accepted non-last beat, o_tdata <= current timer[DATA_WIDTH-1:0].
  - o_tlast=1 when beat_cnt == spp-1. spp=1 gives tlast on every beat.
  - Packet boundaries are never truncated. Deasserting enable mid-packet finishes the current packet, then goes to IDLE.
- On the accepted last beat:
  - pkt_sent_count++ and seqnum++ (12-bit wrap 4095 -> 0).
  - If num_packets != 0 and pkt_sent_count+1 == num_packets -> DONE.
  - Else if enable=0 -> IDLE.
  - Else if gap_cycles == 0 -> SEND back-to-back: reload the stamp and pkt_time on the same edge, o_tvalid stays high with no bubble.
  - Else -> GAP.
- GAP:
  - o_tvalid=0; counter runs 0..gap_cycles-1, then -> SEND with stamp/pkt_time reload.
  - enable=0 during GAP -> IDLE immediately.
  - The gap is exactly gap_cycles cycles with o_tvalid low.
- DONE: o_tvalid=0, done=1; stays until enable=0, then -> IDLE with done cleared.
- Header (o_tuser[127:64]) = {2'b00, has_time=1, eob, seqnum[11:0], length=16'd0, src_sid, next_dst_sid}.
  - eob=1 only on the final packet of a finite run.
  - The header is latched at packet start.
- clear_tx_seqnum: seqnum <= 0 on that edge; wins over a simultaneous increment. Does not disturb an in-flight packet's latched header.
- pkt_sent_count saturates at 16'hFFFF in unlimited mode.
- o_tready is ignored outside SEND. A reset mid-packet aborts immediately with o_tvalid low on the next cycle; the downstream side accepts the truncated packet.

Test Plan:
1. Reset, then enable=1, spp_shift=2, gap=0, num_packets=3, o_tready=1, timer incrementing by 1 from 100 -> 12 beats with no bubbles.
   - tlast on beats 4, 8, 12.
   - pkt_time = 100, 104, 108; o_tdata = 100, 101, 102, 103, ...
   - seqnum 0, 1, 2; eob only on packet 3; done=1; pkt_sent_count=3.
2. spp_shift=0, gap=5, num_packets=0, for 40 cycles -> single-beat packets, each with tlast=1, separated by exactly 5 o_tvalid-low cycles; seqnum increments per packet.
3. Backpressure: o_tready toggled 1,0,0,1 during beat 2 -> o_tdata, o_tlast and o_tuser held for 3 cycles; the next stamp equals the timer at the accept cycle; no beat lost or duplicated.
4. enable dropped on beat 1 of a 16-beat packet -> all 16 beats sent, tlast on beat 16, then IDLE with busy=0; also dropping enable during GAP -> IDLE on the next cycle.
5. Run with seqnum preloaded to 4095 via 4095 packets, then clear_tx_seqnum pulsed on a last-beat accept -> next packet seqnum=0, not 1.
6. spp_shift=15 -> clamped to 2048 beats per packet; reset asserted at beat 500 -> o_tvalid=0, pkt_sent_count=0 and seqnum=0 on the next cycle.
